// File: rtl/instr_prefetch_unit.sv
// Sequential instruction fetcher: one outstanding req/ack fetch feeding a DEPTH-entry {pc, instr} queue toward decode.
// Define PREFETCH_PERF_EN to add saturating fetch/flush counters (perf_fetch_o, perf_flush_o).
module instr_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   mem_req_o,
    output logic [31:0]            mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [31:0]            mem_data_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_addr_i,
    output logic                   instr_valid_o,
    output logic [31:0]            instr_o,
    output logic [31:0]            pc_o,
    output logic [31:0]            pc_plus4_o,
    input  logic                   instr_ready_i,
    output logic [$clog2(DEPTH):0] count_o
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0]            perf_fetch_o,
    output logic [15:0]            perf_flush_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state, state_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic [31:0]   redir_pc;
    logic          unused_addr_bits;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   post_push;
    logic          push, pop;

    assign redir_pc         = {redirect_addr_i[31:2], 2'b00};
    assign unused_addr_bits = ^redirect_addr_i[1:0];

    // Redirect wins over both queue operations in the same cycle.
    assign push      = (state == REQ) && mem_ack_i && !redirect_i;
    assign pop       = (count != '0) && instr_ready_i && !redirect_i;
    assign post_push = count + (AW+1)'(1) - (AW+1)'(pop);

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        case (state)
            IDLE: begin
                if (redirect_i) begin
                    fetch_pc_n = redir_pc;
                    state_n    = REQ;
                end else if (count < FULL) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    fetch_pc_n = redir_pc;
                    state_n    = mem_ack_i ? REQ : DROP;
                end else if (mem_ack_i) begin
                    fetch_pc_n = fetch_pc + 32'd4;
                    state_n    = (post_push < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                // The stale request must still complete before a new one can start.
                if (redirect_i) begin
                    fetch_pc_n = redir_pc;
                    if (mem_ack_i) state_n = REQ;
                end else if (mem_ack_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            fetch_pc   <= START_PC;
            mem_req_o  <= 1'b0;
            mem_addr_o <= START_PC;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            mem_req_o <= (state_n != IDLE);
            if (state_n != DROP) mem_addr_o <= fetch_pc_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= mem_data_i;
        end
    end

    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? q_instr[rd_ptr] : 32'd0;
    assign pc_o          = instr_valid_o ? q_pc[rd_ptr] : 32'd0;
    assign pc_plus4_o    = pc_o + 32'd4;
    assign count_o       = count;

`ifdef PREFETCH_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_fetch_o <= '0;
            perf_flush_o <= '0;
        end else begin
            if (push && perf_fetch_o != 16'hFFFF) perf_fetch_o <= perf_fetch_o + 16'd1;
            if (redirect_i && perf_flush_o != 16'hFFFF) perf_flush_o <= perf_flush_o + 16'd1;
        end
    end
`endif

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the single-cycle CPU datapath. It replaces the CPU's direct PC→instruction-memory lookup when the instruction memory has variable latency.
- Issues sequential word fetches to the instruction memory over a req/ack handshake.
- Buffers returned words with their PC in a small FIFO and presents them to the decode side with valid/ready.
- Discards stale fetches when the core redirects on a branch, jump or jr.

Parameters:
DEPTH, 4, prefetch queue entries (power of two, ≥2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous active-low reset
mem_req_o  output  1  fetch request to instruction memory
mem_addr_o  output  32  fetch word address, bits [1:0] always 00
mem_ack_i  input  1  memory accepts request; mem_data_i valid this cycle
mem_data_i  input  32  fetched instruction word
redirect_i  input  1  core redirect: flush queue, restart at redirect_addr_i
redirect_addr_i  input  32  new fetch PC (bits [1:0] ignored)
instr_valid_o  output  1  queue head valid
instr_o  output  32  queue head instruction
pc_o  output  32  queue head PC
pc_plus4_o  output  32  pc_o + 4, for link/branch-base use
instr_ready_i  input  1  core consumes head this cycle
count_o  output  clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst_i low at a rising edge):
  - state=IDLE, fetch_pc=RESET_PC, queue count=0, pointers=0.
  - mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, count_o=0.
  - instr_o and pc_o=0 while empty.
  - Reset mid-request abandons the request; the memory must tolerate req dropping.
- FSM states:
  - IDLE: mem_req_o=0. Go to REQ when count + 0 < DEPTH and no redirect.
  - REQ: mem_req_o=1, mem_addr_o=fetch_pc. Address is held stable until mem_ack_i.
    - On ack without redirect: push {fetch_pc, mem_data_i}, fetch_pc+=4.
    - After that ack, stay in REQ if post-push count (including any same-cycle pop) < DEPTH, else go to IDLE.
  - DROP: mem_req_o=1 with the stale address held. On ack, discard data and go to IDLE.
- At most one outstanding request. A request is issued only when one queue slot is guaranteed, so a push never overflows.
- mem_req_o and mem_addr_o are registered.
- Throughput: with a zero-wait memory (ack same cycle as req), one instruction is queued per cycle.
- Latency: the first mem_req_o rises the cycle after the first edge with rst_i high. instr_valid_o rises the cycle after the ack.
- Output side:
  - instr_valid_o = (count != 0). instr_o, pc_o and pc_plus4_o are driven from the head entry combinationally.
  - Pop when instr_valid_o & instr_ready_i. instr_ready_i is ignored while empty.
  - A simultaneous push and pop leaves count unchanged.
- Redirect (redirect_i=1), which has priority over push and pop in the same cycle:
  - Queue is flushed (count=0 next cycle); a same-cycle pop is ignored.
  - fetch_pc <= {redirect_addr_i[31:2], 2'b00}.
  - From REQ with mem_ack_i=1 that same cycle: data discarded, next state REQ at the new PC.
  - From REQ with no ack: next state DROP.
  - From IDLE: next state REQ.
  - From DROP: fetch_pc updated, stay in DROP. If the ack arrives that same cycle, go to REQ.
- Arithmetic: fetch_pc and pc_plus4_o wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- mem_ack_i while mem_req_o=0 is ignored.

Optional Feature:
PREFETCH_PERF_EN:
- When defined, adds output ports perf_fetch_o[15:0] and perf_flush_o[15:0].
  - perf_fetch_o counts words pushed into the queue.
  - perf_flush_o counts cycles with redirect_i=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, neither port nor its counters exist. Behaviour is otherwise identical.

Test Plan:
- Zero-wait memory, instr_ready_i=1, RESET_PC=0 → pc_o sequence 0,4,8,C… on consecutive cycles. instr_valid_o is continuous after the first word.
- instr_ready_i=0, zero-wait memory → exactly 4 words queued (count_o=4), then mem_req_o=0. Raising ready for 1 cycle → one new request issued, count returns to 4.
- 3-cycle ack latency, redirect_i=1 with redirect_addr_i=32'h40 one cycle after req → the stale ack's data is dropped. Next mem_addr_o=32'h40 and the first valid pc_o=32'h40.
- Redirect coincident with mem_ack_i and instr_ready_i at count=2 → count_o=0 next cycle, no push. Next request is to the redirect address in the following cycle.
- fetch_pc=32'hFFFF_FFFC acked → pc_plus4_o=0, next mem_addr_o=0.
- rst_i low for 1 cycle while in REQ with 3 entries queued → count_o=0, mem_req_o=0 next cycle. Fetch restarts at RESET_PC. Under PREFETCH_PERF_EN, both perf counters read 0.
